// File: rtl/eq_arith_unit.sv
// OFDM equalizer arithmetic core: signed mean (L=2), complex multiplier (L=3), signed/unsigned divider (L=34).
// Define EQ_DIV_ZERO_SAT_EN to saturate divide-by-zero results instead of returning zero.
module eq_arith_unit (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] mean_a,
  input  logic signed [15:0] mean_b,
  input  logic               mean_sign,
  input  logic               mean_in_stb,
  output logic signed [15:0] mean_c,
  output logic               mean_out_stb,
  input  logic signed [15:0] cm_a_i,
  input  logic signed [15:0] cm_a_q,
  input  logic signed [15:0] cm_b_i,
  input  logic signed [15:0] cm_b_q,
  input  logic               cm_in_stb,
  output logic signed [31:0] cm_p_i,
  output logic signed [31:0] cm_p_q,
  output logic               cm_out_stb,
  input  logic signed [31:0] div_dividend,
  input  logic        [23:0] div_divisor,
  input  logic               div_in_stb,
  output logic signed [31:0] div_quotient,
  output logic               div_out_stb
);

  localparam int DIV_STAGES = 33;

  // ---------------------------------------------------------------- mean unit
  logic signed [15:0] m_a_q, m_b_q;
  logic               m_sign_q, m_stb_q;
  logic signed [15:0] m_s_q, m_s_d;
  logic               m_sign1_q, m_stb1_q;
  logic signed [15:0] m_c_q, m_c_d;
  logic               m_stb2_q;

  // NOTE: combinational blocks assign every output on every path so no latch is inferred.
  always_comb begin
    m_s_d = (m_a_q >>> 1) + (m_b_q >>> 1);
    m_c_d = m_sign1_q ? m_s_q : -m_s_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_a_q     <= '0;
      m_b_q     <= '0;
      m_sign_q  <= 1'b0;
      m_stb_q   <= 1'b0;
      m_s_q     <= '0;
      m_sign1_q <= 1'b0;
      m_stb1_q  <= 1'b0;
      m_c_q     <= '0;
      m_stb2_q  <= 1'b0;
    end else if (enable) begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      m_a_q     <= mean_a;
      m_b_q     <= mean_b;
      m_sign_q  <= mean_sign;
      m_stb_q   <= mean_in_stb;
      m_s_q     <= m_s_d;
      m_sign1_q <= m_sign_q;
      m_stb1_q  <= m_stb_q;
      m_c_q     <= m_c_d;
      m_stb2_q  <= m_stb1_q;
    end
  end

  assign mean_c       = m_c_q;
  assign mean_out_stb = m_stb2_q;

  // ------------------------------------------------------- complex multiplier
  logic signed [15:0] c_ai_q, c_aq_q, c_bi_q, c_bq_q;
  logic               c_stb0_q;
  logic signed [31:0] c_ii_q, c_qq_q, c_iq_q, c_qi_q;
  logic signed [31:0] c_ii_d, c_qq_d, c_iq_d, c_qi_d;
  logic               c_stb1_q;
  logic signed [31:0] c_si_q, c_sq_q, c_si_d, c_sq_d;
  logic               c_stb2_q;
  logic signed [31:0] c_pi_q, c_pq_q;
  logic               c_stb3_q;

  always_comb begin
    c_ii_d = 32'(c_ai_q) * 32'(c_bi_q);
    c_qq_d = 32'(c_aq_q) * 32'(c_bq_q);
    c_iq_d = 32'(c_ai_q) * 32'(c_bq_q);
    c_qi_d = 32'(c_aq_q) * 32'(c_bi_q);
    c_si_d = c_ii_q - c_qq_q;
    c_sq_d = c_iq_q + c_qi_q;
  end

  // The final stage is a plain retiming register that isolates the adders from the output pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      c_ai_q   <= '0;
      c_aq_q   <= '0;
      c_bi_q   <= '0;
      c_bq_q   <= '0;
      c_stb0_q <= 1'b0;
      c_ii_q   <= '0;
      c_qq_q   <= '0;
      c_iq_q   <= '0;
      c_qi_q   <= '0;
      c_stb1_q <= 1'b0;
      c_si_q   <= '0;
      c_sq_q   <= '0;
      c_stb2_q <= 1'b0;
      c_pi_q   <= '0;
      c_pq_q   <= '0;
      c_stb3_q <= 1'b0;
    end else if (enable) begin
      c_ai_q   <= cm_a_i;
      c_aq_q   <= cm_a_q;
      c_bi_q   <= cm_b_i;
      c_bq_q   <= cm_b_q;
      c_stb0_q <= cm_in_stb;
      c_ii_q   <= c_ii_d;
      c_qq_q   <= c_qq_d;
      c_iq_q   <= c_iq_d;
      c_qi_q   <= c_qi_d;
      c_stb1_q <= c_stb0_q;
      c_si_q   <= c_si_d;
      c_sq_q   <= c_sq_d;
      c_stb2_q <= c_stb1_q;
      c_pi_q   <= c_si_q;
      c_pq_q   <= c_sq_q;
      c_stb3_q <= c_stb2_q;
    end
  end

  assign cm_p_i     = c_pi_q;
  assign cm_p_q     = c_pq_q;
  assign cm_out_stb = c_stb3_q;

  // ------------------------------------------------------------------ divider
  // Stage 0 registers the 33-bit magnitude; stages 1..33 each resolve one quotient bit.
  // The shift register starts as the dividend magnitude and fills with quotient bits from the bottom.
  logic [32:0] d_sr_q  [0:DIV_STAGES];
  logic [32:0] d_sr_d  [0:DIV_STAGES];
  logic [23:0] d_rem_q [0:DIV_STAGES];
  logic [23:0] d_rem_d [0:DIV_STAGES];
  logic [23:0] d_dvs_q [0:DIV_STAGES];
  logic [23:0] d_dvs_d [0:DIV_STAGES];
  logic        d_neg_q [0:DIV_STAGES];
  logic        d_neg_d [0:DIV_STAGES];
  logic        d_stb_q [0:DIV_STAGES];
  logic        d_stb_d [0:DIV_STAGES];
  logic [32:0] d_ext;
  logic [24:0] d_trial;
  logic        d_qbit;
  logic [31:0] d_mag;
  logic [31:0] d_quo_q, d_quo_d;
  logic        d_ostb_q;

  always_comb begin
    d_trial    = '0;
    d_qbit     = 1'b0;
    d_ext      = {div_dividend[31], div_dividend};
    d_sr_d[0]  = d_ext[32] ? (~d_ext + 33'd1) : d_ext;
    d_rem_d[0] = '0;
    d_dvs_d[0] = div_divisor;
    d_neg_d[0] = div_dividend[31];
    d_stb_d[0] = div_in_stb;
    for (int i = 1; i <= DIV_STAGES; i++) begin
      d_trial = {d_rem_q[i-1], d_sr_q[i-1][32]};
      d_qbit  = (d_trial >= {1'b0, d_dvs_q[i-1]});
      if (d_qbit) d_trial = d_trial - {1'b0, d_dvs_q[i-1]};
      d_rem_d[i] = d_trial[23:0];
      d_sr_d[i]  = {d_sr_q[i-1][31:0], d_qbit};
      d_dvs_d[i] = d_dvs_q[i-1];
      d_neg_d[i] = d_neg_q[i-1];
      d_stb_d[i] = d_stb_q[i-1];
    end

    d_mag = d_sr_q[DIV_STAGES][31:0];
    if (d_dvs_q[DIV_STAGES] == '0) begin
`ifdef EQ_DIV_ZERO_SAT_EN
      d_quo_d = d_neg_q[DIV_STAGES] ? 32'h8000_0001 : 32'h7FFF_FFFF;
`else
      d_quo_d = '0;
`endif
    end else begin
      d_quo_d = d_neg_q[DIV_STAGES] ? -d_mag : d_mag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: every pipeline stage is cleared, not just the strobes, so all outputs read 0 after reset.
      for (int i = 0; i <= DIV_STAGES; i++) begin
        d_sr_q[i]  <= '0;
        d_rem_q[i] <= '0;
        d_dvs_q[i] <= '0;
        d_neg_q[i] <= 1'b0;
        d_stb_q[i] <= 1'b0;
      end
      d_quo_q  <= '0;
      d_ostb_q <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i <= DIV_STAGES; i++) begin
        d_sr_q[i]  <= d_sr_d[i];
        d_rem_q[i] <= d_rem_d[i];
        d_dvs_q[i] <= d_dvs_d[i];
        d_neg_q[i] <= d_neg_d[i];
        d_stb_q[i] <= d_stb_d[i];
      end
      d_quo_q  <= d_quo_d;
      d_ostb_q <= d_stb_q[DIV_STAGES];
    end
  end

  assign div_quotient = d_quo_q;
  assign div_out_stb  = d_ostb_q;

endmodule

// File: tb/tb_eq_arith_unit.sv
// Self-checking bench for eq_arith_unit: directed corners plus random streams scored per cycle
// against an enabled-cycle-indexed reference model.
module tb_eq_arith_unit;

  logic               clock = 1'b0;
  logic               reset, enable;
  logic signed [15:0] mean_a, mean_b;
  logic               mean_sign, mean_in_stb;
  logic signed [15:0] mean_c;
  logic               mean_out_stb;
  logic signed [15:0] cm_a_i, cm_a_q, cm_b_i, cm_b_q;
  logic               cm_in_stb;
  logic signed [31:0] cm_p_i, cm_p_q;
  logic               cm_out_stb;
  logic signed [31:0] div_dividend;
  logic        [23:0] div_divisor;
  logic               div_in_stb;
  logic signed [31:0] div_quotient;
  logic               div_out_stb;

  eq_arith_unit dut (
    .clock(clock), .reset(reset), .enable(enable),
    .mean_a(mean_a), .mean_b(mean_b), .mean_sign(mean_sign), .mean_in_stb(mean_in_stb),
    .mean_c(mean_c), .mean_out_stb(mean_out_stb),
    .cm_a_i(cm_a_i), .cm_a_q(cm_a_q), .cm_b_i(cm_b_i), .cm_b_q(cm_b_q), .cm_in_stb(cm_in_stb),
    .cm_p_i(cm_p_i), .cm_p_q(cm_p_q), .cm_out_stb(cm_out_stb),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_in_stb(div_in_stb),
    .div_quotient(div_quotient), .div_out_stb(div_out_stb)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint      due;
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  exp_t        mq[$], cq[$], dq[$];
  longint      ecount = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          m_es, c_es, d_es;
  logic [31:0] m_ev, c_ev0, c_ev1, d_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model, straight from the arithmetic rules.
  function automatic logic signed [15:0] mean_ref(input logic signed [15:0] a, input logic signed [15:0] b,
                                                  input logic sg);
    int s;
    s = (int'(a) >>> 1) + (int'(b) >>> 1);
    if (!sg) s = -s;
    return 16'(s);
  endfunction

  function automatic logic [63:0] cm_ref(input logic signed [15:0] ai, input logic signed [15:0] aq,
                                         input logic signed [15:0] bi, input logic signed [15:0] bq);
    longint pi, pq;
    pi = longint'(ai) * longint'(bi) - longint'(aq) * longint'(bq);
    pq = longint'(ai) * longint'(bq) + longint'(aq) * longint'(bi);
    return {pq[31:0], pi[31:0]};
  endfunction

  function automatic logic [31:0] div_ref(input logic signed [31:0] x, input logic [23:0] d);
    longint mag, q;
    if (d == 24'd0) begin
`ifdef EQ_DIV_ZERO_SAT_EN
      return (x < 0) ? 32'h8000_0001 : 32'h7FFF_FFFF;
`else
      return 32'h0;
`endif
    end
    mag = (x < 0) ? -longint'(x) : longint'(x);
    q   = mag / longint'(d);
    if (x < 0) q = -q;
    return q[31:0];
  endfunction

  // One clock: advance the model with what the DUT sampled, then compare all outputs.
  task automatic step();
    exp_t        e;
    logic [63:0] cp;
    bit          rst_s, en_s;
    rst_s = reset;
    en_s  = enable;
    @(posedge clock);
    #1;
    if (rst_s) begin
      mq.delete(); cq.delete(); dq.delete();
      m_es = 1'b0; c_es = 1'b0; d_es = 1'b0;
      m_ev = '0; c_ev0 = '0; c_ev1 = '0; d_ev = '0;
      check("rst_mean_out_stb", 32'(mean_out_stb), 32'd0);
      check("rst_mean_c",       32'(mean_c),       32'd0);
      check("rst_cm_out_stb",   32'(cm_out_stb),   32'd0);
      check("rst_cm_p_i",       cm_p_i,            32'd0);
      check("rst_cm_p_q",       cm_p_q,            32'd0);
      check("rst_div_out_stb",  32'(div_out_stb),  32'd0);
      check("rst_div_quotient", div_quotient,      32'd0);
      return;
    end
    if (en_s) begin
      ecount++;
      if (mean_in_stb) begin
        e.due = ecount + 2;
        e.v0  = 32'(mean_ref(mean_a, mean_b, mean_sign));
        e.v1  = '0;
        mq.push_back(e);
      end
      if (cm_in_stb) begin
        cp    = cm_ref(cm_a_i, cm_a_q, cm_b_i, cm_b_q);
        e.due = ecount + 3;
        e.v0  = cp[31:0];
        e.v1  = cp[63:32];
        cq.push_back(e);
      end
      if (div_in_stb) begin
        e.due = ecount + 34;
        e.v0  = div_ref(div_dividend, div_divisor);
        e.v1  = '0;
        dq.push_back(e);
      end
      m_es = (mq.size() > 0) && (mq[0].due == ecount);
      if (m_es) begin m_ev = mq[0].v0; void'(mq.pop_front()); end
      c_es = (cq.size() > 0) && (cq[0].due == ecount);
      if (c_es) begin c_ev0 = cq[0].v0; c_ev1 = cq[0].v1; void'(cq.pop_front()); end
      d_es = (dq.size() > 0) && (dq[0].due == ecount);
      if (d_es) begin d_ev = dq[0].v0; void'(dq.pop_front()); end
    end
    check("mean_out_stb", 32'(mean_out_stb), 32'(m_es));
    if (m_es) check("mean_c", 32'(mean_c), m_ev);
    check("cm_out_stb", 32'(cm_out_stb), 32'(c_es));
    if (c_es) begin
      check("cm_p_i", cm_p_i, c_ev0);
      check("cm_p_q", cm_p_q, c_ev1);
    end
    check("div_out_stb", 32'(div_out_stb), 32'(d_es));
    if (d_es) check("div_quotient", div_quotient, d_ev);
  endtask

  task automatic idle(input int n);
    mean_in_stb = 1'b0;
    cm_in_stb   = 1'b0;
    div_in_stb  = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive_random();
    mean_a      = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
    mean_b      = 16'($urandom);
    mean_sign   = 1'($urandom);
    mean_in_stb = ($urandom_range(0, 3) != 0);
    cm_a_i      = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
    cm_a_q      = 16'($urandom);
    cm_b_i      = 16'($urandom);
    cm_b_q      = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
    cm_in_stb   = ($urandom_range(0, 3) != 0);
    div_dividend = ($urandom_range(0, 15) == 0) ? 32'sh8000_0000 : 32'($urandom);
    if ($urandom_range(0, 7) == 0)      div_divisor = 24'($urandom_range(0, 3));
    else if ($urandom_range(0, 1) == 1) div_divisor = 24'($urandom_range(1, 255));
    else                                div_divisor = 24'($urandom);
    div_in_stb  = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    mean_a = '0; mean_b = '0; mean_sign = 1'b0; mean_in_stb = 1'b0;
    cm_a_i = '0; cm_a_q = '0; cm_b_i = '0; cm_b_q = '0; cm_in_stb = 1'b0;
    div_dividend = '0; div_divisor = '0; div_in_stb = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Directed corners on all three units.
    mean_a = 16'sd100; mean_b = 16'sd50; mean_sign = 1'b1; mean_in_stb = 1'b1;
    cm_a_i = 16'sd3; cm_a_q = 16'sd4; cm_b_i = 16'sd1; cm_b_q = -16'sd2; cm_in_stb = 1'b1;
    div_dividend = 32'sd1000; div_divisor = 24'd7; div_in_stb = 1'b1;
    step();
    mean_sign = 1'b0;
    cm_a_i = 16'sh8000; cm_a_q = 16'sh8000; cm_b_i = 16'sh8000; cm_b_q = 16'sh8000;
    div_dividend = -32'sd1000;
    step();
    mean_a = -16'sd3; mean_b = -16'sd3; mean_sign = 1'b1;
    cm_a_i = 16'sh8000; cm_a_q = 16'sh7FFF; cm_b_i = 16'sh8000; cm_b_q = 16'sh7FFF;
    div_dividend = 32'sd5; div_divisor = 24'd9;
    step();
    mean_a = 16'sh8000; mean_b = 16'sh8000; mean_sign = 1'b0;
    cm_in_stb = 1'b0;
    div_dividend = 32'sh8000_0000; div_divisor = 24'd1;
    step();
    mean_in_stb = 1'b0;
    div_dividend = -32'sd5; div_divisor = 24'd0;
    step();
    div_dividend = 32'sd7; div_divisor = 24'd0;
    step();
    div_dividend = 32'sh7FFF_FFFF; div_divisor = 24'hFF_FFFF;
    step();
    idle(40);

    // Back-to-back divider stream with random traffic on the other units.
    for (int n = 0; n < 64; n++) begin
      drive_random();
      div_dividend = 32'(n * 1000);
      div_divisor  = 24'd1000;
      div_in_stb   = 1'b1;
      step();
    end
    idle(40);

    // Random streams with a five-cycle enable gap.
    for (int i = 0; i < 60; i++) begin
      drive_random();
      enable = !(i >= 20 && i < 25);
      step();
    end
    enable = 1'b1;
    idle(40);

    // Single-cycle reset while results are in flight.
    for (int i = 0; i < 20; i++) begin
      drive_random();
      step();
    end
    drive_random();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_random();
      step();
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
